// File: rtl/spi_slave_shifter_if.sv
// SPI pin and RX/TX FIFO request bundle for the SPI responder.
// Latency: none, wires only.
// Backpressure: none here; the responder reacts to empty_tx and full_rx.
interface spi_slave_shifter_if;
  logic       sck;
  logic       cs_;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] data_tx;
  logic       read_rq;
  logic       empty_tx;
  logic [7:0] data_rx;
  logic       write_rq;
  logic       full_rx;
  logic       underrun;
  logic       overrun;
  logic       frame_err;

  // Responder side.
  modport slave (
    input  sck, cs_, mosi, data_tx, empty_tx, full_rx,
    output miso, miso_oe, read_rq, data_rx, write_rq, underrun, overrun, frame_err
  );

  // Pin driver / FIFO side.
  modport master (
    output sck, cs_, mosi, data_tx, empty_tx, full_rx,
    input  miso, miso_oe, read_rq, data_rx, write_rq, underrun, overrun, frame_err
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 responder: oversampled pins, 8-bit MSB-first, TX prefetch and RX write.
// Latency: SYNC_STAGES+1 clk cycles from an sck/cs_ pin edge to its effect.
// Backpressure: empty TX sends IDLE_BYTE (underrun); full RX drops the byte (overrun).
module spi_slave_shifter #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input logic                clk,
  input logic                reset,
  spi_slave_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
  logic                   sck_d;
  logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall;

  logic [7:0] tx_next, tx_shift, tx_shift_nxt;
  logic [7:0] rx_shift, rx_shift_nxt, data_rx, data_rx_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       tx_vld, rd_wait, read_rq, read_rq_nxt, rd_out, take_next;
  logic       reload, reload_nxt;
  logic       miso, miso_nxt, miso_oe, miso_oe_nxt;
  logic       write_rq, write_nxt, underrun, underrun_nxt;
  logic       overrun, overrun_nxt, frame_err, frame_err_nxt;

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // A read is outstanding from the request cycle until data_tx is captured.
  assign rd_out   = read_rq | rd_wait;

  assign bus.miso      = miso;
  assign bus.miso_oe   = miso_oe;
  assign bus.read_rq   = read_rq;
  assign bus.data_rx   = data_rx;
  assign bus.write_rq  = write_rq;
  assign bus.underrun  = underrun;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;

  // Pin synchronizers; cs_ resets to deasserted so reset never starts a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sr  <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], bus.sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], bus.cs_};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.mosi};
      sck_d   <= sck_s;
    end
  end

  // State and datapath registers, all loaded from the next-state logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      data_rx   <= '0;
      bit_cnt   <= '0;
      reload    <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      write_rq  <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_shift  <= tx_shift_nxt;
      rx_shift  <= rx_shift_nxt;
      data_rx   <= data_rx_nxt;
      bit_cnt   <= bit_cnt_nxt;
      reload    <= reload_nxt;
      miso      <= miso_nxt;
      miso_oe   <= miso_oe_nxt;
      write_rq  <= write_nxt;
      underrun  <= underrun_nxt;
      overrun   <= overrun_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // TX prefetch: one request at a time, data captured the cycle after the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_next <= '0;
      tx_vld  <= 1'b0;
      rd_wait <= 1'b0;
      read_rq <= 1'b0;
    end else begin
      read_rq <= read_rq_nxt;
      rd_wait <= read_rq;
      if (rd_wait) begin
        tx_next <= bus.data_tx;
        tx_vld  <= 1'b1;
      end else if (take_next) begin
        tx_vld  <= 1'b0;
      end
    end
  end

  // Next-state, shift and pulse logic; cs_ deassertion overrides everything last.
  always_comb begin
    state_nxt     = state;
    tx_shift_nxt  = tx_shift;
    rx_shift_nxt  = rx_shift;
    data_rx_nxt   = data_rx;
    bit_cnt_nxt   = bit_cnt;
    reload_nxt    = reload;
    take_next     = 1'b0;
    write_nxt     = 1'b0;
    underrun_nxt  = 1'b0;
    overrun_nxt   = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_nxt  = '0;
        reload_nxt   = 1'b0;
        tx_shift_nxt = '0;
        if (!cs_s) state_nxt = LOAD;
      end
      LOAD: begin
        if (!rd_out) begin
          if (tx_vld) begin
            tx_shift_nxt = tx_next;
            take_next    = 1'b1;
          end else begin
            tx_shift_nxt = IDLE_BYTE;
            underrun_nxt = 1'b1;
          end
          bit_cnt_nxt = '0;
          reload_nxt  = 1'b0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          rx_shift_nxt = {rx_shift[6:0], mosi_s};
          if (bit_cnt == 3'd7) begin
            data_rx_nxt = {rx_shift[6:0], mosi_s};
            write_nxt   = ~bus.full_rx;
            overrun_nxt = bus.full_rx;
            bit_cnt_nxt = '0;
            reload_nxt  = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else if (sck_fall) begin
          if (reload) begin
            // Data still in flight from the FIFO is kept for the byte after this one.
            if (tx_vld) begin
              tx_shift_nxt = tx_next;
              take_next    = 1'b1;
            end else begin
              tx_shift_nxt = IDLE_BYTE;
              underrun_nxt = 1'b1;
            end
            reload_nxt = 1'b0;
          end else begin
            tx_shift_nxt = {tx_shift[6:0], 1'b0};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A byte completing in the same cycle leaves bit_cnt_nxt at 0, so it is not an error.
    if (state != IDLE && cs_s) begin
      frame_err_nxt = (bit_cnt_nxt != 3'd0);
      state_nxt     = IDLE;
      bit_cnt_nxt   = '0;
      reload_nxt    = 1'b0;
      tx_shift_nxt  = '0;
      take_next     = 1'b0;
      underrun_nxt  = 1'b0;
    end

    read_rq_nxt = ~tx_vld & ~bus.empty_tx & ~read_rq & ~rd_wait;
    miso_oe_nxt = (state_nxt != IDLE);
    miso_nxt    = miso_oe_nxt & tx_shift_nxt[7];
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: directed frames then randomized frames vs a byte-level model.
module tb_spi_slave_shifter;

  localparam int HALF = 5;

  logic clk;
  logic reset;
  spi_slave_shifter_if bus();

  spi_slave_shifter #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_wr = 0, n_und = 0, n_ovr = 0, n_fe = 0, n_rd = 0, n_wide = 0;
  logic [7:0] rx_log[$];
  logic [7:0] fifo_q[$];
  logic [7:0] model_q[$];
  logic [7:0] m_out[4];
  logic [7:0] m_in[4];
  logic p_wr = 0, p_und = 0, p_ovr = 0, p_fe = 0;

  // TX FIFO: pops on a request, data shows up the following cycle.
  always @(posedge clk) begin
    if (bus.read_rq && fifo_q.size() > 0) bus.data_tx <= fifo_q.pop_front();
    bus.empty_tx <= (fifo_q.size() == 0);
  end

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.write_rq) begin
      n_wr++;
      rx_log.push_back(bus.data_rx);
    end
    if (bus.underrun)  n_und++;
    if (bus.overrun)   n_ovr++;
    if (bus.frame_err) n_fe++;
    if (bus.read_rq)   n_rd++;
    if ((bus.write_rq && p_wr) || (bus.underrun && p_und) ||
        (bus.overrun && p_ovr) || (bus.frame_err && p_fe)) n_wide++;
    p_wr  = bus.write_rq;
    p_und = bus.underrun;
    p_ovr = bus.overrun;
    p_fe  = bus.frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    fifo_q.push_back(b);
    model_q.push_back(b);
  endtask

  // Master side of one frame; frame ends with sck still high unless aborted.
  task automatic frame(input int nbytes, input int abort_rises);
    int  rises;
    bit  done;
    rises = 0;
    done  = 0;
    bus.cs_ = 1'b0;
    wait_cyc(10);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (!done) begin
          bus.mosi = m_out[b][i];
          wait_cyc(HALF);
          bus.sck = 1'b1;
          m_in[b][i] = bus.miso;
          rises++;
          wait_cyc(HALF);
          if (abort_rises > 0 && rises == abort_rises) begin
            bus.sck = 1'b0;
            wait_cyc(HALF);
            done = 1;
          end else if (b == nbytes - 1 && i == 0) begin
            done = 1;
          end else begin
            bus.sck = 1'b0;
          end
        end
      end
    end
    bus.cs_ = 1'b1;
    wait_cyc(HALF);
    bus.sck = 1'b0;
    wait_cyc(12);
  endtask

  // Runs a frame and checks it against the byte-level model.
  task automatic do_case(input string tag, input int nbytes, input int abort_rises, input bit full);
    logic [7:0] exp_miso[4];
    int exp_und, started, w0, u0, o0, f0, exp_wr;
    started = (abort_rises > 0) ? 1 : nbytes;
    exp_und = 0;
    for (int b = 0; b < started; b++) begin
      if (model_q.size() > 0) exp_miso[b] = model_q.pop_front();
      else begin
        exp_miso[b] = 8'hFF;
        exp_und++;
      end
    end
    rx_log.delete();
    w0 = n_wr; u0 = n_und; o0 = n_ovr; f0 = n_fe;
    bus.full_rx = full;
    frame(nbytes, abort_rises);
    bus.full_rx = 1'b0;
    exp_wr = (abort_rises > 0 || full) ? 0 : nbytes;
    chk({tag, " write_rq count"}, 32'(n_wr - w0), 32'(exp_wr));
    chk({tag, " underrun count"}, 32'(n_und - u0), 32'(exp_und));
    chk({tag, " overrun count"}, 32'(n_ovr - o0), 32'((abort_rises == 0 && full) ? nbytes : 0));
    chk({tag, " frame_err count"}, 32'(n_fe - f0), 32'((abort_rises > 0) ? 1 : 0));
    if (abort_rises == 0) begin
      for (int b = 0; b < nbytes; b++) begin
        chk($sformatf("%s miso byte %0d", tag, b), 32'(m_in[b]), 32'(exp_miso[b]));
        if (b < rx_log.size()) chk($sformatf("%s rx byte %0d", tag, b), 32'(rx_log[b]), 32'(m_out[b]));
      end
      chk({tag, " data_rx held"}, 32'(bus.data_rx), 32'(m_out[nbytes-1]));
    end
    chk({tag, " miso_oe idle"}, 32'(bus.miso_oe), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " miso"},      32'(bus.miso),      32'(0));
    chk({tag, " miso_oe"},   32'(bus.miso_oe),   32'(0));
    chk({tag, " read_rq"},   32'(bus.read_rq),   32'(0));
    chk({tag, " write_rq"},  32'(bus.write_rq),  32'(0));
    chk({tag, " data_rx"},   32'(bus.data_rx),   32'(0));
    chk({tag, " underrun"},  32'(bus.underrun),  32'(0));
    chk({tag, " overrun"},   32'(bus.overrun),   32'(0));
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'(0));
  endtask

  initial begin
    reset        = 1'b0;
    bus.sck      = 1'b0;
    bus.cs_      = 1'b1;
    bus.mosi     = 1'b0;
    bus.full_rx  = 1'b0;
    bus.data_tx  = 8'h00;
    bus.empty_tx = 1'b1;
    wait_cyc(3);
    chk_reset_outputs("reset");
    reset = 1'b1;
    wait_cyc(4);

    // Preloaded A5 out, 3C in.
    push_tx(8'hA5);
    wait_cyc(6);
    chk("t1 read_rq before cs", 32'(n_rd), 32'(1));
    m_out[0] = 8'h3C;
    do_case("t1", 1, 0, 1'b0);

    // Two-byte frame with two queued TX bytes.
    push_tx(8'h01);
    push_tx(8'h02);
    wait_cyc(6);
    m_out[0] = 8'hF0;
    m_out[1] = 8'h0F;
    do_case("t2", 2, 0, 1'b0);

    // Empty TX FIFO.
    m_out[0] = 8'h5A;
    do_case("t3", 1, 0, 1'b0);

    // RX FIFO full.
    push_tx(8'h77);
    wait_cyc(6);
    m_out[0] = 8'hC3;
    do_case("t4", 1, 0, 1'b1);

    // Abort after 5 rises, then a clean frame.
    push_tx(8'h96);
    wait_cyc(6);
    m_out[0] = 8'hE1;
    do_case("t5 abort", 1, 5, 1'b0);
    push_tx(8'h4B);
    wait_cyc(6);
    m_out[0] = 8'h2D;
    do_case("t5 next", 1, 0, 1'b0);

    // Reset mid-byte.
    push_tx(8'h81);
    wait_cyc(6);
    bus.cs_ = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = i[0];
      wait_cyc(HALF);
      bus.sck = 1'b1;
      wait_cyc(HALF);
      bus.sck = 1'b0;
    end
    #1 reset = 1'b0;
    #1 chk_reset_outputs("midreset");
    fifo_q.delete();
    model_q.delete();
    bus.cs_ = 1'b1;
    bus.sck = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(4);
    push_tx(8'h6E);
    wait_cyc(6);
    m_out[0] = 8'h19;
    do_case("t6 after reset", 1, 0, 1'b0);

    // Randomized frames: TX supply, frame length and RX full vary.
    for (int k = 0; k < 12; k++) begin
      int npush, nb;
      bit full;
      npush = $urandom_range(0, 3);
      nb    = $urandom_range(1, 3);
      full  = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < npush; j++) push_tx(8'($urandom));
      for (int b = 0; b < nb; b++) m_out[b] = 8'($urandom);
      wait_cyc(8);
      do_case($sformatf("rand%0d", k), nb, 0, full);
    end

    chk("pulse widths", 32'(n_wide), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
